// File: rtl/nco_freq_calibrator_if.sv
// Control/measurement bundle between the NCO calibration controller and its
// surroundings: run control, reference/NCO observation and corrected increment.
interface nco_freq_calibrator_if;
  logic               start;
  logic               clearCorr;
  logic        [31:0] phaseIncNom;
  logic               refTick;
  logic               ncoMsb;
  logic        [31:0] phaseIncOut;
  logic               outValid;
  logic               busy;
  logic               locked;
  logic               fail;
  logic signed [15:0] errLast;

  modport master (
    output start, clearCorr, phaseIncNom, refTick, ncoMsb,
    input  phaseIncOut, outValid, busy, locked, fail, errLast
  );

  modport slave (
    input  start, clearCorr, phaseIncNom, refTick, ncoMsb,
    output phaseIncOut, outValid, busy, locked, fail, errLast
  );
endinterface

// File: rtl/nco_freq_calibrator.sv
// Closed-loop NCO phase-increment calibration: counts NCO overflows over a gate of
// reference ticks and steers a signed correction word until the count matches.
module nco_freq_calibrator #(
  parameter int GATE_TICKS    = 16,
  parameter int EXP_COUNT     = 1000,
  parameter int CNT_W         = 24,
  parameter int GAIN_SHIFT    = 8,
  parameter int TOL           = 1,
  parameter int MAX_ITER      = 8,
  parameter int CORR_LIM      = 1048576,
  parameter int SETTLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  nco_freq_calibrator_if.slave bus
);

  localparam int TICK_W = $clog2(GATE_TICKS + 1);
  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int ERR_W  = CNT_W + 1;
  localparam int STEP_W = ERR_W + GAIN_SHIFT;
  localparam int WIDE_W = ((STEP_W > 32) ? STEP_W : 32) + 2;

  localparam logic signed [ERR_W-1:0]  EXP_S  = ERR_W'(EXP_COUNT);
  localparam logic signed [ERR_W-1:0]  TOL_S  = ERR_W'(TOL);
  localparam logic signed [WIDE_W-1:0] LIM_W  = WIDE_W'(CORR_LIM);
  localparam logic signed [31:0]       LIM_32 = 32'(CORR_LIM);

  typedef enum logic [2:0] {IDLE, ARM, COUNT, UPDATE, SETTLE, DONE, FAIL} state_t;

  state_t                    state, stateNext;
  logic                      ncoMsb_p1;
  logic        [CNT_W-1:0]   ovfCnt;
  logic        [TICK_W-1:0]  tickCnt;
  logic        [ITER_W-1:0]  iter;
  logic        [SET_W-1:0]   settleCnt;
  logic        [31:0]        nomReg;
  logic signed [31:0]        corr;
  logic        [31:0]        phaseIncOut;
  logic                      outValid;
  logic signed [15:0]        errLast;

  logic                      edgeHit, startAcc, lastTick, settleDone;
  logic                      withinTol, iterOut;
  logic        [ITER_W-1:0]  iterNext;
  logic signed [ERR_W-1:0]   err;
  logic signed [WIDE_W-1:0]  stepWide;
  logic signed [31:0]        corrNext, corrEff;

  function automatic logic [CNT_W-1:0] satCount(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && !(&c)) ? c + 1'b1 : c;
  endfunction

  // Sum is at most (2^32-1) + (2^31-1), so bit 33 only ever means negative.
  function automatic logic [31:0] satInc(input logic [31:0] nom, input logic signed [31:0] c);
    logic signed [33:0] s;
    s = $signed({2'b00, nom}) + $signed({{2{c[31]}}, c});
    if (s[33]) return '0;
    if (s[32]) return '1;
    return s[31:0];
  endfunction

  function automatic logic signed [31:0] clampCorr(input logic signed [WIDE_W-1:0] v);
    if (v > LIM_W)  return LIM_32;
    if (v < -LIM_W) return -LIM_32;
    return v[31:0];
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [ERR_W-1:0] e);
    logic signed [WIDE_W-1:0] w;
    w = WIDE_W'(e);
    if (w > WIDE_W'(32767))  return 16'sh7FFF;
    if (w < -WIDE_W'(32767)) return -16'sh7FFF;
    return w[15:0];
  endfunction

  assign edgeHit    = bus.ncoMsb & ~ncoMsb_p1;
  assign startAcc   = (state inside {IDLE, DONE, FAIL}) && bus.start;
  assign lastTick   = bus.refTick && (tickCnt == TICK_W'(GATE_TICKS - 1));
  assign settleDone = (settleCnt == SET_W'(SETTLE_CYCLES - 1));
  assign err        = EXP_S - $signed({1'b0, ovfCnt});
  assign withinTol  = (err <= TOL_S) && (err >= -TOL_S);
  assign iterNext   = iter + 1'b1;
  assign iterOut    = (iterNext >= ITER_W'(MAX_ITER));
  assign stepWide   = WIDE_W'(err) <<< GAIN_SHIFT;
  assign corrNext   = clampCorr(WIDE_W'(corr) + stepWide);
  // A clear arriving with start takes effect before the start uses corr.
  assign corrEff    = bus.clearCorr ? '0 : corr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE, FAIL: if (bus.start) stateNext = SETTLE;
      ARM:              if (bus.refTick) stateNext = COUNT;
      COUNT:            if (lastTick) stateNext = UPDATE;
      UPDATE: begin
        if (withinTol)    stateNext = DONE;
        else if (iterOut) stateNext = FAIL;
        else              stateNext = SETTLE;
      end
      SETTLE:           if (settleDone) stateNext = ARM;
      default:          stateNext = IDLE;
    endcase
  end

  // Measurement/correction datapath; output word is registered, so outValid and
  // the new value appear together one cycle after start acceptance or UPDATE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ncoMsb_p1   <= 1'b0;
      ovfCnt      <= '0;
      tickCnt     <= '0;
      iter        <= '0;
      settleCnt   <= '0;
      nomReg      <= '0;
      corr        <= '0;
      phaseIncOut <= '0;
      outValid    <= 1'b0;
      errLast     <= '0;
    end else begin
      ncoMsb_p1 <= bus.ncoMsb;
      outValid  <= 1'b0;
      case (state)
        IDLE, DONE, FAIL: begin
          if (bus.clearCorr) corr <= '0;
          if (startAcc) begin
            nomReg      <= bus.phaseIncNom;
            iter        <= '0;
            settleCnt   <= '0;
            phaseIncOut <= satInc(bus.phaseIncNom, corrEff);
            outValid    <= 1'b1;
          end
        end
        ARM: begin
          if (bus.refTick) begin
            ovfCnt  <= '0;
            tickCnt <= '0;
          end
        end
        COUNT: begin
          ovfCnt <= satCount(ovfCnt, edgeHit);
          if (bus.refTick) tickCnt <= tickCnt + 1'b1;
        end
        UPDATE: begin
          errLast <= sat16(err);
          iter    <= iterNext;
          if (!withinTol && !iterOut) begin
            corr        <= corrNext;
            phaseIncOut <= satInc(nomReg, corrNext);
            outValid    <= 1'b1;
            settleCnt   <= '0;
          end
        end
        SETTLE: settleCnt <= settleDone ? '0 : settleCnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.phaseIncOut = phaseIncOut;
  assign bus.outValid    = outValid;
  assign bus.errLast     = errLast;
  assign bus.busy        = state inside {ARM, COUNT, UPDATE, SETTLE};
  assign bus.locked      = (state == DONE);
  assign bus.fail        = (state == FAIL);

endmodule

// File: tb/tb_nco_freq_calibrator.sv
// Directed bench for nco_freq_calibrator: table of calibration runs plus
// hand-written sequences for reset, busy-start and correction-clear corners.
module tb_nco_freq_calibrator;

  localparam logic [31:0] NOM = 32'd858993459;

  typedef struct {
    bit          doReset;
    bit          clr;
    logic [31:0] nom;
    int          nWin;
    int          e0, e1, e2;
    bit          openEdge;
    bit          closeEdge;
    bit          expLocked;
    bit          expFail;
    logic [31:0] expPhase;
    int          expErr;
    int          expOv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   ovCount = 0;
  vec_t vecs[10];

  always #5 clk = ~clk;

  nco_freq_calibrator_if bus();

  nco_freq_calibrator #(
    .GATE_TICKS(2), .EXP_COUNT(100), .CNT_W(7), .GAIN_SHIFT(8), .TOL(1),
    .MAX_ITER(3), .CORR_LIM(4096), .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) if (bus.outValid === 1'b1) ovCount++;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit doReset, input bit clr, input logic [31:0] nom,
                              input int nWin, input int e0, input int e1, input int e2,
                              input bit openEdge, input bit closeEdge, input bit expLocked,
                              input bit expFail, input logic [31:0] expPhase,
                              input int expErr, input int expOv);
    vec_t v;
    v.doReset = doReset; v.clr = clr; v.nom = nom; v.nWin = nWin;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.openEdge = openEdge; v.closeEdge = closeEdge;
    v.expLocked = expLocked; v.expFail = expFail; v.expPhase = expPhase;
    v.expErr = expErr; v.expOv = expOv;
    return v;
  endfunction

  task automatic doReset();
    rst = 1'b1;
    bus.start = 1'b0; bus.clearCorr = 1'b0; bus.refTick = 1'b0; bus.ncoMsb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulseStart(input logic [31:0] nom, input bit clr);
    bus.phaseIncNom = nom; bus.clearCorr = clr; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.clearCorr = 1'b0;
  endtask

  // Opening tick, n NCO rising edges with one mid-window tick, closing tick.
  task automatic window(input int n, input bit openEdge, input bit closeEdge);
    bus.ncoMsb = 1'b0; bus.refTick = 1'b0;
    repeat (8) @(negedge clk);
    bus.refTick = 1'b1; bus.ncoMsb = openEdge;
    @(negedge clk);
    bus.refTick = 1'b0; bus.ncoMsb = 1'b0;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bus.ncoMsb = 1'b1;
      @(negedge clk);
      bus.ncoMsb = 1'b0; bus.refTick = (i == n / 2);
      @(negedge clk);
      bus.refTick = 1'b0;
    end
    bus.refTick = 1'b1; bus.ncoMsb = closeEdge;
    @(negedge clk);
    bus.refTick = 1'b0; bus.ncoMsb = 1'b0;
  endtask

  task automatic runVec(input int idx, input vec_t v);
    int base;
    int e;
    if (v.doReset) doReset();
    base = ovCount;
    pulseStart(v.nom, v.clr);
    for (int w = 0; w < v.nWin; w++) begin
      e = (w == 0) ? v.e0 : ((w == 1) ? v.e1 : v.e2);
      window(e, v.openEdge && (w == 0), v.closeEdge && (w == v.nWin - 1));
    end
    repeat (4) @(negedge clk);
    check($sformatf("v%0d_locked", idx), bus.locked, v.expLocked);
    check($sformatf("v%0d_failflag", idx), bus.fail, v.expFail);
    check($sformatf("v%0d_phase", idx), bus.phaseIncOut, v.expPhase);
    check($sformatf("v%0d_errLast", idx), bus.errLast, v.expErr);
    check($sformatf("v%0d_outValidCount", idx), ovCount - base, v.expOv);
  endtask

  initial begin
    int base;
    bus.start = 1'b0; bus.clearCorr = 1'b0; bus.phaseIncNom = '0;
    bus.refTick = 1'b0; bus.ncoMsb = 1'b0;

    //            rst clr nom           nW  e0   e1   e2 open close lock fail phase                 err ov
    vecs[0] = mk(1, 0, NOM,          1, 100,   0,  0, 0, 0, 1, 0, NOM,                   0, 1);
    vecs[1] = mk(1, 0, NOM,          2,  98, 100,  0, 0, 0, 1, 0, NOM + 32'd512,         0, 2);
    vecs[2] = mk(1, 0, NOM,          3,  90,  90, 90, 0, 0, 0, 1, NOM + 32'd4096,       10, 3);
    vecs[3] = mk(1, 0, 32'hFFFFFF00, 2,  95, 100,  0, 0, 0, 1, 0, 32'hFFFFFFFF,          0, 2);
    vecs[4] = mk(1, 0, NOM,          1,  98,   0,  0, 0, 1, 1, 0, NOM,                   1, 1);
    vecs[5] = mk(1, 0, NOM,          2,  98, 100,  0, 1, 0, 1, 0, NOM + 32'd512,         0, 2);
    vecs[6] = mk(1, 0, NOM,          2, 130, 100,  0, 0, 0, 1, 0, NOM - 32'd4096,        0, 2);
    vecs[7] = mk(1, 0, NOM,          2, 103, 100,  0, 0, 0, 1, 0, NOM - 32'd768,         0, 2);
    vecs[8] = mk(0, 0, NOM,          1, 100,   0,  0, 0, 0, 1, 0, NOM - 32'd768,         0, 1);
    vecs[9] = mk(0, 1, NOM,          1, 100,   0,  0, 0, 0, 1, 0, NOM,                   0, 1);

    doReset();
    check("rst_phase", bus.phaseIncOut, 0);
    check("rst_outValid", bus.outValid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_failflag", bus.fail, 0);
    check("rst_errLast", bus.errLast, 0);

    for (int i = 0; i < 10; i++) runVec(i, vecs[i]);

    // start while busy must neither relatch the nominal nor pulse outValid
    doReset();
    base = ovCount;
    pulseStart(NOM, 1'b0);
    check("start_outValid", bus.outValid, 1);
    check("start_phase", bus.phaseIncOut, NOM);
    check("start_busy", bus.busy, 1);
    pulseStart(32'h12345678, 1'b0);
    check("busyStart_outValid", bus.outValid, 0);
    check("busyStart_phase", bus.phaseIncOut, NOM);
    window(98, 1'b0, 1'b0);
    window(100, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("busyStart_finalPhase", bus.phaseIncOut, NOM + 32'd512);
    check("busyStart_locked", bus.locked, 1);
    check("busyStart_ovCount", ovCount - base, 2);

    // reset in the middle of a counting window
    doReset();
    pulseStart(NOM, 1'b0);
    window(103, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    bus.refTick = 1'b1;
    @(negedge clk);
    bus.refTick = 1'b0;
    repeat (3) begin
      bus.ncoMsb = 1'b1; @(negedge clk);
      bus.ncoMsb = 1'b0; @(negedge clk);
    end
    check("midRun_busy", bus.busy, 1);
    check("midRun_errLast", bus.errLast, -3);
    rst = 1'b1;
    @(negedge clk);
    check("midRst_phase", bus.phaseIncOut, 0);
    check("midRst_outValid", bus.outValid, 0);
    check("midRst_busy", bus.busy, 0);
    check("midRst_locked", bus.locked, 0);
    check("midRst_failflag", bus.fail, 0);
    check("midRst_errLast", bus.errLast, 0);
    rst = 1'b0;
    @(negedge clk);
    pulseStart(NOM, 1'b0);
    check("postRst_phase", bus.phaseIncOut, NOM);

    // clearCorr on its own while locked, then a separate start
    doReset();
    pulseStart(NOM, 1'b0);
    window(103, 1'b0, 1'b0);
    window(100, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("clr_preLocked", bus.locked, 1);
    check("clr_prePhase", bus.phaseIncOut, NOM - 32'd768);
    bus.clearCorr = 1'b1;
    @(negedge clk);
    bus.clearCorr = 1'b0;
    @(negedge clk);
    pulseStart(NOM, 1'b0);
    check("clr_outValid", bus.outValid, 1);
    check("clr_phase", bus.phaseIncOut, NOM);
    check("clr_lockedCleared", bus.locked, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nco_freq_calibrator.md
# nco_freq_calibrator

Closed-loop calibration controller for the demodulator NCO phase increment. It measures NCO overflow count over a gate of reference ticks and compares it with the expected count. It then iteratively adjusts a signed correction word added to the nominal phase increment, until the error is within tolerance or the iteration budget is spent. It sits between the configuration register holding the nominal increment and the NCO's phase-increment input, replacing the fixed shift-sum correction with a measured one.

## Interface
- GATE_TICKS, 16: reference ticks per measurement window (≥1)
- EXP_COUNT, 1000: expected NCO overflows per window
- CNT_W, 24: overflow counter width; counter saturates at all-ones
- GAIN_SHIFT, 8: correction step = error << GAIN_SHIFT
- TOL, 1: lock when |error| ≤ TOL
- MAX_ITER, 8: measurement iterations before fail
- CORR_LIM, 1048576: |corr| clamp
- SETTLE_CYCLES, 4: wait after each update before re-arming (≥2, covers downstream add/sub latency)
- CLK  in  1  clock; all logic rising-edge
- RST  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a calibration run; ignored while busy
- clearCorr  in  1  zero corr; honoured only in IDLE/DONE/FAIL
- phaseIncNom  in  32  nominal increment, sampled on accepted start
- refTick  in  1  one-cycle reference pulse
- ncoMsb  in  1  NCO phase accumulator MSB (same clock domain)
- phaseIncOut  out  32  nominal + corr, saturated to [0, 2^32−1]
- outValid  out  1  one-cycle pulse when phaseIncOut changes
- busy  out  1  high in ARM/COUNT/UPDATE/SETTLE
- locked  out  1  high in DONE until next start/RST
- fail  out  1  high in FAIL until next start/RST
- errLast  out  16  signed last error, saturated to ±32767

## Operation
- States: IDLE, ARM, COUNT, UPDATE, SETTLE, DONE, FAIL.
- Reset: state IDLE; corr=0; phaseIncOut=0; outValid, busy, locked, fail =0; errLast=0; iter=0; counters 0; edge register 0.
- IDLE/DONE/FAIL + start: latch phaseIncNom, iter=0, clear locked/fail, drive phaseIncOut=nom+corr with outValid pulse, → SETTLE. corr persists across runs unless clearCorr or RST.
- ARM: wait refTick; on it clear overflow and tick counters → COUNT.
- COUNT: overflow = ncoMsb & ~ncoMsb_d (registered edge). Each refTick increments tickCnt; the window closes on the GATE_TICKS-th tick. An edge coinciding with the closing tick is counted; an edge coinciding with the opening tick (ARM→COUNT) is not. → UPDATE.
- UPDATE (one cycle): err = EXP_COUNT − measured (signed, CNT_W+1 bits); errLast updated; iter+1.
  - |err| ≤ TOL → DONE, locked=1, no output change.
  - else if iter reaches MAX_ITER → FAIL, no output change.
  - else corr = clamp(corr + (err << GAIN_SHIFT), ±CORR_LIM); phaseIncOut recomputed; outValid=1 → SETTLE.
- SETTLE: count SETTLE_CYCLES, → ARM.
- Arithmetic: corr signed 32-bit; sum nom+corr in 34-bit signed, clamp to 0 or 0xFFFFFFFF.
- Positive err (NCO slow) raises increment.

## Timing
- outValid asserted the cycle after UPDATE/start acceptance, coincident with the new phaseIncOut; held value otherwise.
- Edge detect adds 1 cycle latency; window measured against registered edges consistently.
- Run length ≈ iterations × (SETTLE_CYCLES + wait-for-tick + GATE_TICKS tick periods).
- clearCorr and start same cycle: clear first, then start with corr=0.
- start during busy: ignored, no state effect.
- RST mid-run: next cycle in reset state; phaseIncOut=0.
- Counter saturates at 2^CNT_W−1, never wraps.

## Test plan
- Bench GATE_TICKS=2, EXP_COUNT=100, GAIN_SHIFT=8, TOL=1: nom=858993459, 100 edges per window → one outValid (nom), then locked=1 after the first window, errLast=0, phaseIncOut=858993459.
- Same with 98 edges in first window, then 100: corr=+512, phaseIncOut=858993971, outValid pulse, locked after second window, errLast=0.
- Always 90 edges, MAX_ITER=3, CORR_LIM=4096: corr steps 2560 → 4096 (clamped); fail=1 after 3rd window; phaseIncOut=nom+4096.
- nom=0xFFFFFF00, 95 edges → corr=+1280, phaseIncOut saturates 0xFFFFFFFF.
- Edge coincident with closing refTick is counted (99+1 → locked). Edge coincident with opening tick is excluded.
- RST asserted mid-COUNT → all outputs 0 next cycle. start while busy is ignored. clearCorr in DONE, then start → outValid with phaseIncOut=nom.
